instr_fetch: RTL and testbench
==============================

// Module: instr_fetch
// PURPOSE
//  Initiator side of the instruction-memory stb/ack bus. Drives the fetch address, waits for the ack,
//  and buffers {pc, instr} pairs in a small FIFO for the decode stage. Handles decode back-pressure,
//  branch/jump redirects that flush in-flight work, and misaligned-target or ack-timeout faults.
//  Sits between the core's PC/redirect logic and instr_mem.
// PARAMETERS
//  PC_RESET     32'h0000_0000  first fetch address after reset (default taken from `PC_RESET)
//  FIFO_DEPTH   2              fetched-instruction buffer entries (power of 2, >=2)
//  ACK_TIMEOUT  16             cycles o_istb may stay high without i_iack before a fault
// PORTS
//  clk            in   1   single clock; all logic on rising edge
//  rst            in   1   reset, synchronous, active-high
//  o_iaddr        out  32  fetch address to instruction memory
//  o_istb         out  1   fetch request strobe
//  i_iack         in   1   memory ack; may assert in the same cycle as o_istb (zero-latency memory)
//  i_idata        in   32  instruction word, valid when i_iack=1
//  o_valid        out  1   head FIFO entry valid toward decode
//  o_instr        out  32  head FIFO instruction
//  o_pc           out  32  address of o_instr
//  i_ready        in   1   decode consumes head entry when o_valid & i_ready
//  i_redirect     in   1   one-cycle pulse: change PC (branch/jump/trap)
//  i_redirect_pc  in   32  new PC, sampled when i_redirect=1
//  o_fault        out  1   sticky fault flag
//  o_fault_code   out  2   0=none, 1=MISALIGN (redirect target [1:0]!=0), 2=TIMEOUT
// BEHAVIOUR
//  Interface: one clock; reset is synchronous and active-high.
//  Reset: pc=PC_RESET, FIFO empty, state=REQ, timeout counter=0, o_valid=0, o_fault=0,
//   o_fault_code=0, o_istb=0 and o_iaddr=PC_RESET during reset. o_istb rises in the first cycle after
//   rst falls. Reset mid-transaction drops in-flight data; no entry survives.
//  States: REQ (issuing/awaiting ack), FAULT (o_istb=0 until redirect or reset).
//  o_istb = (state==REQ) & (count<FIFO_DEPTH). Uses registered count only; no i_ready->o_istb path.
//  o_iaddr = pc (registered). Both are held stable while o_istb=1 and i_iack=0.
//  Ack (o_istb & i_iack, no redirect): push {pc, i_idata}, pc<=pc+4 (mod 2^32 wrap), timeout cnt<=0.
//   Sustained throughput is 1 instr/cycle with zero-latency ack and i_ready=1.
//  Pop: o_valid & i_ready. Push and pop in the same cycle leave count unchanged.
//   When full, o_istb=0 and pc is held until a pop frees a slot.
//  Timeout: cnt increments each cycle with o_istb=1 & i_iack=0. At cnt==ACK_TIMEOUT-1 with no ack:
//   state<=FAULT, code=2.
//  Redirect (highest priority, including over a same-cycle ack, whose data is discarded):
//   FIFO flushed; cnt<=0; o_valid=0 next cycle.
//   If i_redirect_pc[1:0]==0: pc<=i_redirect_pc, state<=REQ, fault cleared.
//   Else: state<=FAULT, code=1, pc unchanged.
//  Simultaneous pop and redirect: the pop completes (decode owns that entry); the flush removes the rest.
//  FAULT: no requests are issued and FIFO contents stay poppable. Only redirect or rst leaves FAULT.
// STRUCTURE
//  parameters.vh: PC_RESET, fault code localparams FC_NONE/FC_MISALIGN/FC_TIMEOUT.
//  Sub-module fetch_fifo: 64-bit wide, FIFO_DEPTH deep, sync flush, push/pop/count/full/empty,
//   first-word-fall-through head.
//  instr_fetch contains the PC register, state register, timeout counter and stb logic.
// TESTING
//  1 Reset then release, zero-latency memory, i_ready=1 -> o_iaddr 0x0,0x4,0x8 on consecutive
//    cycles; o_pc/o_instr match memory one cycle later.
//  2 i_ready=0 -> after 2 acks (pc 0x0,0x4) o_istb=0 and o_iaddr holds 0x8. Raise i_ready ->
//    o_istb reasserts same cycle count<2.
//  3 Memory acks 3 cycles late -> o_iaddr/o_istb stable throughout; no duplicate or missing pc.
//  4 i_redirect to 0x100 in a cycle with i_iack=1 -> the acked word is never delivered;
//    next o_iaddr=0x100; FIFO empty.
//  5 i_redirect to 0x102 -> o_fault=1, code=1, o_istb=0. Then redirect to 0x200 -> fault clears,
//    fetch resumes at 0x200.
//  6 i_iack tied 0 -> o_fault=1, code=2 exactly ACK_TIMEOUT cycles after o_istb rises. Assert rst
//    mid-fault -> all outputs return to reset values.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
//   fetch_entry_t : {pc, instr} pair buffered between memory and decode
//   FC_*          : fault codes reported on o_fault_code
package instr_fetch_pkg;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned ENTRY_W     = 2 * XLEN;
    localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_0000;

    localparam logic [1:0] FC_NONE     = 2'd0;
    localparam logic [1:0] FC_MISALIGN = 2'd1;
    localparam logic [1:0] FC_TIMEOUT  = 2'd2;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    // Instruction targets must be word aligned.
    function automatic logic is_word_aligned(input logic [XLEN-1:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/instr_fetch_fifo.sv
// Fetched-instruction buffer: first-word-fall-through FIFO of fetch_entry_t.
//   clk, rst   : clock, synchronous active-high reset
//   flush      : synchronous clear (dominates push and pop)
//   push/push_data, pop : write and read strobes (ignored when full/empty)
//   head       : oldest entry, valid whenever empty=0
//   count/full/empty : occupancy status, all from registered state
module instr_fetch_fifo
    import instr_fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         push,
    input  fetch_entry_t                 push_data,
    input  logic                         pop,
    output fetch_entry_t                 head,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    fetch_entry_t     mem_q [DEPTH];
    fetch_entry_t     mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic do_push;
    logic do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head    = mem_q[rd_ptr_q];
    assign do_push = push & ~full & ~flush;
    assign do_pop  = pop & ~empty & ~flush;

    // Pointer/count update; DEPTH is a power of two so pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is data-only; occupancy reset alone invalidates it.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch initiator on the stb/ack instruction-memory bus.
//   clk, rst                 : clock, synchronous active-high reset
//   o_iaddr, o_istb          : fetch request (held while waiting for ack)
//   i_iack, i_idata          : memory response (may be zero latency)
//   o_valid, o_instr, o_pc   : head of the fetched-instruction buffer
//   i_ready                  : decode consumes head when o_valid & i_ready
//   i_redirect, i_redirect_pc: branch/jump/trap PC change, flushes buffer
//   o_fault, o_fault_code    : sticky fault (misaligned target / ack timeout)
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] PC_RESET    = PC_RESET_DEFAULT,
    parameter int unsigned FIFO_DEPTH  = 2,
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] o_iaddr,
    output logic        o_istb,
    input  logic        i_iack,
    input  logic [31:0] i_idata,
    output logic        o_valid,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc,
    input  logic        i_ready,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_fault,
    output logic [1:0]  o_fault_code
);

    localparam logic [0:0]  ST_REQ   = 1'b0;
    localparam logic [0:0]  ST_FAULT = 1'b1;
    localparam int unsigned CNT_W    = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned TO_W     = $clog2(ACK_TIMEOUT + 1);

    logic [31:0]     pc_q, pc_d;
    logic [0:0]      state_q, state_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic [1:0]      fault_code_q, fault_code_d;

    fetch_entry_t     fifo_head;
    fetch_entry_t     fifo_wdata;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_push;
    logic             fifo_pop;
    logic             istb;
    logic             ack;

    // Request only from registered state; rst gates it so the bus stays idle during reset.
    assign istb       = ~rst & (state_q == ST_REQ) & (fifo_count < CNT_W'(FIFO_DEPTH));
    assign ack        = istb & i_iack;
    assign fifo_push  = ack & ~i_redirect & ~fifo_full;
    assign fifo_pop   = ~fifo_empty & i_ready;
    assign fifo_wdata = '{pc: pc_q, instr: i_idata};

    instr_fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (i_redirect),
        .push      (fifo_push),
        .push_data (fifo_wdata),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Next-state: redirect beats ack, ack beats timeout.
    always_comb begin
        pc_d         = pc_q;
        state_d      = state_q;
        to_cnt_d     = to_cnt_q;
        fault_code_d = fault_code_q;
        if (i_redirect) begin
            to_cnt_d = '0;
            if (is_word_aligned(i_redirect_pc)) begin
                pc_d         = i_redirect_pc;
                state_d      = ST_REQ;
                fault_code_d = FC_NONE;
            end else begin
                state_d      = ST_FAULT;
                fault_code_d = FC_MISALIGN;
            end
        end else if (ack) begin
            pc_d     = pc_q + 32'd4;
            to_cnt_d = '0;
        end else if (istb) begin
            if (to_cnt_q == TO_W'(ACK_TIMEOUT - 1)) begin
                state_d      = ST_FAULT;
                fault_code_d = FC_TIMEOUT;
                to_cnt_d     = '0;
            end else begin
                to_cnt_d = to_cnt_q + TO_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q         <= PC_RESET;
            state_q      <= ST_REQ;
            to_cnt_q     <= '0;
            fault_code_q <= FC_NONE;
        end else begin
            pc_q         <= pc_d;
            state_q      <= state_d;
            to_cnt_q     <= to_cnt_d;
            fault_code_q <= fault_code_d;
        end
    end

    assign o_iaddr      = pc_q;
    assign o_istb       = istb;
    assign o_valid      = ~fifo_empty;
    assign o_pc         = fifo_head.pc;
    assign o_instr      = fifo_head.instr;
    assign o_fault      = (fault_code_q != FC_NONE);
    assign o_fault_code = fault_code_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: per-cycle vector table plus multi-cycle sequences
// for a slow memory and the ack timeout.
module tb_instr_fetch;

    logic        clk;
    logic        rst;
    logic [31:0] o_iaddr;
    logic        o_istb;
    logic        i_iack;
    logic [31:0] i_idata;
    logic        o_valid;
    logic [31:0] o_instr;
    logic [31:0] o_pc;
    logic        i_ready;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
    logic        o_fault;
    logic [1:0]  o_fault_code;

    int n_cmp = 0;
    int n_mis = 0;
    int mem_lat = 0;      // ack after this many waiting cycles; >=1000 means never
    int wait_cnt = 0;

    instr_fetch dut (
        .clk           (clk),
        .rst           (rst),
        .o_iaddr       (o_iaddr),
        .o_istb        (o_istb),
        .i_iack        (i_iack),
        .i_idata       (i_idata),
        .o_valid       (o_valid),
        .o_instr       (o_instr),
        .o_pc          (o_pc),
        .i_ready       (i_ready),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .o_fault       (o_fault),
        .o_fault_code  (o_fault_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return 32'hC0DE_0000 ^ {a[15:0], a[15:0]} ^ 32'h0000_1357;
    endfunction

    // Memory model: decides ack on the falling edge from the registered request.
    initial begin
        i_iack  = 1'b0;
        i_idata = '0;
        forever begin
            @(negedge clk);
            i_idata = mdata(o_iaddr);
            if (o_istb && mem_lat < 1000) begin
                if (wait_cnt >= mem_lat) begin
                    i_iack   = 1'b1;
                    wait_cnt = 0;
                end else begin
                    i_iack   = 1'b0;
                    wait_cnt = wait_cnt + 1;
                end
            end else begin
                i_iack   = 1'b0;
                wait_cnt = 0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_mis = n_mis + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rst;
        logic        ready;
        logic        redir;
        logic [31:0] redir_pc;
        logic        e_istb;
        logic [31:0] e_iaddr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [1:0]  e_code;
    } vec_t;

    vec_t vecs [17];

    function automatic vec_t mk(input logic r, input logic rdy, input logic rd,
                                input logic [31:0] rpc, input logic istb,
                                input logic [31:0] ia, input logic v,
                                input logic [31:0] pc, input logic [1:0] code);
        vec_t t;
        t.rst = r; t.ready = rdy; t.redir = rd; t.redir_pc = rpc;
        t.e_istb = istb; t.e_iaddr = ia; t.e_valid = v; t.e_pc = pc; t.e_code = code;
        return t;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        i_redirect = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int got;
        int budget;
        logic        last_istb;
        logic [31:0] last_addr;
        logic [31:0] exp_pc;

        // Each row: expected outputs seen this cycle, then inputs applied for the next edge.
        vecs[0]  = mk(1, 0, 0, 0,            0, 32'h0,        0, 0,            2'd0);
        vecs[1]  = mk(0, 0, 0, 0,            0, 32'h0,        0, 0,            2'd0);
        vecs[2]  = mk(0, 0, 0, 0,            1, 32'h4,        1, 32'h0,        2'd0);
        vecs[3]  = mk(0, 0, 0, 0,            0, 32'h8,        1, 32'h0,        2'd0);
        vecs[4]  = mk(0, 1, 0, 0,            0, 32'h8,        1, 32'h0,        2'd0);
        vecs[5]  = mk(0, 1, 0, 0,            1, 32'h8,        1, 32'h4,        2'd0);
        vecs[6]  = mk(0, 1, 0, 0,            1, 32'hC,        1, 32'h8,        2'd0);
        vecs[7]  = mk(0, 1, 0, 0,            1, 32'h10,       1, 32'hC,        2'd0);
        vecs[8]  = mk(0, 1, 1, 32'h100,      1, 32'h14,       1, 32'h10,       2'd0);
        vecs[9]  = mk(0, 1, 0, 0,            1, 32'h100,      0, 0,            2'd0);
        vecs[10] = mk(0, 1, 1, 32'h102,      1, 32'h104,      1, 32'h100,      2'd0);
        vecs[11] = mk(0, 1, 0, 0,            0, 32'h104,      0, 0,            2'd1);
        vecs[12] = mk(0, 1, 1, 32'h200,      0, 32'h104,      0, 0,            2'd1);
        vecs[13] = mk(0, 1, 0, 0,            1, 32'h200,      0, 0,            2'd0);
        vecs[14] = mk(0, 1, 1, 32'hFFFF_FFFC,1, 32'h204,      1, 32'h200,      2'd0);
        vecs[15] = mk(0, 1, 0, 0,            1, 32'hFFFF_FFFC,0, 0,            2'd0);
        vecs[16] = mk(0, 1, 0, 0,            1, 32'h0,        1, 32'hFFFF_FFFC,2'd0);

        i_ready       = 1'b0;
        i_redirect_pc = '0;
        mem_lat       = 0;
        do_reset();

        for (int i = 0; i < 17; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d.istb", i),  32'(o_istb),  32'(vecs[i].e_istb));
            chk($sformatf("vec%0d.iaddr", i), o_iaddr,      vecs[i].e_iaddr);
            chk($sformatf("vec%0d.valid", i), 32'(o_valid), 32'(vecs[i].e_valid));
            if (vecs[i].e_valid) begin
                chk($sformatf("vec%0d.pc", i),    o_pc,    vecs[i].e_pc);
                chk($sformatf("vec%0d.instr", i), o_instr, mdata(vecs[i].e_pc));
            end
            chk($sformatf("vec%0d.fault", i), 32'(o_fault), 32'(vecs[i].e_code != 2'd0));
            chk($sformatf("vec%0d.code", i),  32'(o_fault_code), 32'(vecs[i].e_code));
            rst           = vecs[i].rst;
            i_ready       = vecs[i].ready;
            i_redirect    = vecs[i].redir;
            i_redirect_pc = vecs[i].redir_pc;
        end

        // Slow memory: request held stable, pcs delivered in order without gaps.
        do_reset();
        mem_lat   = 3;
        i_ready   = 1'b1;
        rst       = 1'b0;
        got       = 0;
        budget    = 60;
        exp_pc    = 32'h0;
        last_istb = 1'b1;
        last_addr = 32'h0;
        while (got < 4 && budget > 0) begin
            @(posedge clk);
            #1;
            budget = budget - 1;
            if (last_istb && !i_iack) begin
                chk("slow.hold_istb", 32'(o_istb), 32'd1);
                chk("slow.hold_addr", o_iaddr, last_addr);
            end
            last_istb = o_istb;
            last_addr = o_iaddr;
            if (o_valid) begin
                chk("slow.pc", o_pc, exp_pc);
                chk("slow.instr", o_instr, mdata(exp_pc));
                exp_pc = exp_pc + 32'd4;
                got    = got + 1;
            end
        end
        chk("slow.delivered", 32'(got), 32'd4);

        // Ack never comes: fault exactly 16 cycles after the request rises.
        do_reset();
        mem_lat = 1000;
        i_ready = 1'b0;
        rst     = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk);
            #1;
            if (k == 15) begin
                chk("to.fault_before", 32'(o_fault), 32'd0);
                chk("to.istb_before", 32'(o_istb), 32'd1);
            end
        end
        chk("to.fault", 32'(o_fault), 32'd1);
        chk("to.code", 32'(o_fault_code), 32'd2);
        chk("to.istb", 32'(o_istb), 32'd0);
        chk("to.iaddr", o_iaddr, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        chk("to.sticky", 32'(o_fault_code), 32'd2);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst.istb", 32'(o_istb), 32'd0);
        chk("rst.iaddr", o_iaddr, 32'h0);
        chk("rst.valid", 32'(o_valid), 32'd0);
        chk("rst.fault", 32'(o_fault), 32'd0);
        chk("rst.code", 32'(o_fault_code), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
